lutram_fifo16: RTL and testbench

//  16-entry first-word-fall-through FIFO built on 16-deep LUT dual-port storage.
//  - Write port = synchronous-write address/WE side of the storage.
//  - Read port = asynchronous dual-port read side of the storage.

---
 rtl/lutram_fifo16_pkg.sv | 11 +
 rtl/lutram_fifo16_lutram_16xw.sv | 26 ++
 rtl/lutram_fifo16.sv | 100 ++++++++++
 tb/tb_lutram_fifo16.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lutram_fifo16_pkg.sv
// Shared sizing constants and pointer/count types for the 16-entry LUT-RAM FIFO.
package lutram_fifo16_pkg;

  localparam int LFIFO_DEPTH = 16;
  localparam int LFIFO_AW    = 4;
  localparam int LFIFO_CW    = 5;

  typedef logic [LFIFO_AW-1:0] lfifo_ptr_t;
  typedef logic [LFIFO_CW-1:0] lfifo_cnt_t;

endpackage

// File: rtl/lutram_fifo16_lutram_16xw.sv
// WIDTH x 16 distributed storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module lutram_16xw
  import lutram_fifo16_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             WE,
  input  lfifo_ptr_t       WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  lfifo_ptr_t       RADDR,
  output logic [WIDTH-1:0] RDATA
);

  logic [WIDTH-1:0] mem_q [LFIFO_DEPTH];

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem_q[WADDR] <= WDATA;
    end
  end

  assign RDATA = mem_q[RADDR];

endmodule

// File: rtl/lutram_fifo16.sv
// 16-entry first-word-fall-through FIFO over LUT-RAM storage.
// Optional sticky OVERFLOW/UNDERFLOW outputs when LUTRAM_FIFO16_ERR_FLAGS_EN is defined.
module lutram_fifo16
  import lutram_fifo16_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             EMPTY,
  output logic [LFIFO_CW-1:0] COUNT
`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
  ,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
`endif
);

  lfifo_ptr_t wr_ptr_q, wr_ptr_d;
  lfifo_ptr_t rd_ptr_q, rd_ptr_d;
  lfifo_cnt_t count_q, count_d;
  logic       empty_q, empty_d;
  logic       full_q, full_d;
  logic       wr_acc, rd_acc;

  // Flags are judged on the registered state, so a read on an empty FIFO is
  // rejected even if a write lands on the same edge (no write-through).
  always_comb begin
    wr_acc   = WR_EN & ~full_q;
    rd_acc   = RD_EN & ~empty_q;
    wr_ptr_d = wr_ptr_q + LFIFO_AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + LFIFO_AW'(rd_acc);
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + LFIFO_CW'(1);
      2'b01:   count_d = count_q - LFIFO_CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == LFIFO_CW'(LFIFO_DEPTH));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  lutram_16xw #(.WIDTH(WIDTH)) u_mem (
    .CLK   (CLK),
    .WE    (wr_acc),
    .WADDR (wr_ptr_q),
    .WDATA (WR_DATA),
    .RADDR (rd_ptr_q),
    .RDATA (RD_DATA)
  );

  assign FULL  = full_q;
  assign EMPTY = empty_q;
  assign COUNT = count_q;

`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (WR_EN & full_q);
    underflow_d = underflow_q | (RD_EN & empty_q);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_lutram_fifo16.sv
// Scoreboard bench for lutram_fifo16: driver updates a queue-based model,
// monitor compares DUT status and head word on every falling edge.
module tb_lutram_fifo16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       FULL;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       EMPTY;
  logic [4:0] COUNT;
`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
  logic       OVERFLOW;
  logic       UNDERFLOW;
`endif

  lutram_fifo16 #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .RD_EN   (RD_EN),
    .RD_DATA (RD_DATA),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT)
`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
    ,
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int count;
    bit pop;
  } rec_t;

  rec_t       rec_q[$];
  logic [7:0] data_q[$];
  int         mcnt;
  bit         mon_en;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides acceptance from occupancy alone.
  task automatic cycle(input bit wr, input bit rd, input logic [7:0] d);
    rec_t r;
    bit   wacc, racc;
    @(posedge CLK);
    #1;
    WR_EN   = wr;
    RD_EN   = rd;
    WR_DATA = d;
    wacc    = wr && (mcnt < 16);
    racc    = rd && (mcnt > 0);
    r.count = mcnt;
    r.pop   = racc;
    rec_q.push_back(r);
    if (wacc) data_q.push_back(d);
    mcnt = mcnt + int'(wacc) - int'(racc);
  endtask

  task automatic reset_mid();
    @(posedge CLK);
    #1;
    WR_EN  = 1'b0;
    RD_EN  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("count_before_reset", {27'd0, COUNT}, mcnt);
    #1;
    RESET = 1'b1;
    #1;
    chk("reset_async_count", {27'd0, COUNT}, 0);
    chk("reset_async_empty", {31'd0, EMPTY}, 1);
    chk("reset_async_full", {31'd0, FULL}, 0);
`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
    chk("reset_overflow", {31'd0, OVERFLOW}, 0);
    chk("reset_underflow", {31'd0, UNDERFLOW}, 0);
`endif
    #2;
    RESET = 1'b0;
    mcnt  = 0;
    data_q.delete();
    rec_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge CLK);
      if (mon_en && rec_q.size() != 0) begin
        r = rec_q.pop_front();
        chk("count", {27'd0, COUNT}, r.count);
        chk("empty", {31'd0, EMPTY}, (r.count == 0) ? 1 : 0);
        chk("full", {31'd0, FULL}, (r.count == 16) ? 1 : 0);
        if (r.count > 0) chk("rd_data", {24'd0, RD_DATA}, {24'd0, data_q[0]});
        if (r.pop) void'(data_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    int wp, rp;
    checks  = 0;
    errors  = 0;
    mcnt    = 0;
    mon_en  = 1'b0;
    RESET   = 1'b1;
    WR_EN   = 1'b0;
    RD_EN   = 1'b0;
    WR_DATA = 8'h00;
    #12;
    chk("init_count", {27'd0, COUNT}, 0);
    chk("init_empty", {31'd0, EMPTY}, 1);
    chk("init_full", {31'd0, FULL}, 0);
`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
    chk("init_overflow", {31'd0, OVERFLOW}, 0);
    chk("init_underflow", {31'd0, UNDERFLOW}, 0);
`endif
    RESET  = 1'b0;
    mon_en = 1'b1;

    // three writes, head visible the cycle after the first write
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'h11 + 8'(i));
    cycle(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // fill, rejected 17th write, drain
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i));
    cycle(1, 0, 8'hAA);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // pointer wrap
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // simultaneous requests at full and at empty
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'h80 + 8'(i));
    cycle(1, 1, 8'hEE);
    for (int i = 0; i < 15; i++) cycle(0, 1, 8'h00);
    cycle(1, 1, 8'h5A);
    cycle(0, 0, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

    // reset mid-stream at occupancy 7
    for (int i = 0; i < 7; i++) cycle(1, 0, 8'hC0 + 8'(i));
    reset_mid();
    cycle(1, 0, 8'h33);
    cycle(0, 0, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);

`ifdef LUTRAM_FIFO16_ERR_FLAGS_EN
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);
    chk("underflow_set", {31'd0, UNDERFLOW}, 1);
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i));
    cycle(1, 0, 8'hAA);
    cycle(0, 0, 8'h00);
    chk("overflow_set", {31'd0, OVERFLOW}, 1);
    chk("underflow_held", {31'd0, UNDERFLOW}, 1);
    reset_mid();
    cycle(0, 0, 8'h00);
`endif

    // randomized phases alternating write-heavy and read-heavy traffic
    for (int ph = 0; ph < 8; ph++) begin
      wp = (ph % 2 == 0) ? 75 : 30;
      rp = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 200; i++)
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
    end
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00);
    @(posedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
